// File: rtl/imem_pkg.sv
// imem_pkg: shared constants for the loadable instruction memory
package imem_pkg;
  localparam logic [15:0] NOP_WORD = 16'hF000;
  localparam logic [0:0]  S_LOAD   = 1'b0;
  localparam logic [0:0]  S_RUN    = 1'b1;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x DATA_W storage, one write port, one registered read port
module imem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int IW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_sync_loadable.sv
// imem_sync_loadable: run-time loadable IF-stage instruction memory with
// stall/flush control; unwritten, out-of-range and killed fetches read as NOP.
module imem_sync_loadable
  import imem_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 6,
  parameter int          DEPTH    = 16,
  parameter logic [15:0] NOP      = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
  output logic              running,
  output logic [ADDR_W:0]   ld_cnt
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic              state_q, state_d;
  logic [DEPTH-1:0]  wr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              valid_q, valid_d, src_q, src_d, err_q;
  logic              halt_go, start_go, ld_in, pc_in, ld_wr, ld_bad, fetch, kill, rd_en;
  logic [IW-1:0]     ld_idx, pc_idx;
  logic [DATA_W-1:0] rdata;
  assign ld_idx   = ld_addr[IW-1:0];
  assign pc_idx   = pc[IW-1:0];
  assign start_go = state_q == S_LOAD && start && !halt;
  assign halt_go  = state_q == S_RUN && halt && !start;
  assign state_d  = start_go ? S_RUN : halt_go ? S_LOAD : state_q;
  assign ld_in    = {1'b0, ld_addr} < DEPTH_L;
  assign pc_in    = {1'b0, pc} < DEPTH_L;
  assign ld_wr    = state_q == S_LOAD && ld_en && ld_in;
  assign ld_bad   = state_q == S_LOAD && ld_en && !ld_in;
  // Leaving RUN takes priority over any fetch decision in the same cycle.
  assign kill     = state_q == S_LOAD || halt_go || flush;
  assign fetch    = !kill && !stall && fetch_req;
  assign rd_en    = fetch && pc_in && wr_q[pc_idx];
  // src_q picks array data vs NOP; the array's read register holds when re is low.
  assign valid_d  = kill ? 1'b0 : stall ? valid_q : fetch;
  assign src_d    = kill ? 1'b0 : fetch ? rd_en : src_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      wr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      err_q   <= ld_bad || (fetch && !pc_in);
      if (ld_wr) wr_q[ld_idx] <= 1'b1;
      if (ld_wr && !wr_q[ld_idx]) cnt_q <= cnt_q + 1'b1;
    end
  end
  imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk     (clk),
    .we_i    (ld_wr),
    .waddr_i (ld_idx),
    .wdata_i (ld_data),
    .re_i    (rd_en),
    .raddr_i (pc_idx),
    .rdata_o (rdata)
  );
  assign instr       = src_q ? rdata : DATA_W'(NOP);
  assign instr_valid = valid_q;
  assign addr_err    = err_q;
  assign running     = state_q == S_RUN;
  assign ld_cnt      = cnt_q;
endmodule

// File: tb/tb_imem_sync_loadable.sv
// tb_imem_sync_loadable: directed self-checking bench for the loadable imem
module tb_imem_sync_loadable;
  logic        clk = 0, rst_n = 0, start = 0, halt = 0, ld_en = 0, fetch_req = 0, stall = 0, flush = 0;
  logic [5:0]  ld_addr = 0, pc = 0;
  logic [15:0] ld_data = 0, instr;
  logic        instr_valid, addr_err, running;
  logic [6:0]  ld_cnt;
  int          n_pass = 0, n_total = 0;
  imem_sync_loadable dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .pc(pc), .fetch_req(fetch_req),
    .stall(stall), .flush(flush), .instr(instr), .instr_valid(instr_valid),
    .addr_err(addr_err), .running(running), .ld_cnt(ld_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic ld(input logic [5:0] a, input logic [15:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 0;
  endtask
  task automatic fe(input logic [5:0] a);
    fetch_req = 1; pc = a;
    tick;
  endtask
  initial begin
    tick; tick;
    chk("rst_instr", instr, 16'hF000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_running", running, 0);
    chk("rst_cnt", ld_cnt, 0);
    rst_n = 1;
    tick;
    ld(3, 16'h3333); chk("cnt_w3", ld_cnt, 1);
    ld(3, 16'h3334); chk("cnt_w3_again", ld_cnt, 1);
    ld(4, 16'h4444); chk("cnt_w4", ld_cnt, 2);
    ld(0, 16'h2213); chk("cnt_w0", ld_cnt, 3);
    chk("err_ok_load", addr_err, 0);
    ld(20, 16'hBEEF);
    chk("err_ld_oor", addr_err, 1);
    chk("cnt_ld_oor", ld_cnt, 3);
    tick;
    chk("err_ld_pulse", addr_err, 0);
    fetch_req = 1; pc = 0;
    tick;
    chk("load_fetch_idle", instr_valid, 0);
    fetch_req = 0; start = 1;
    tick;
    start = 0;
    chk("running_after_start", running, 1);
    chk("valid_after_start", instr_valid, 0);
    fe(0);
    chk("f0_instr", instr, 16'h2213);
    chk("f0_valid", instr_valid, 1);
    fe(5);
    chk("f5_unwritten", instr, 16'hF000);
    chk("f5_valid", instr_valid, 1);
    fe(3);
    chk("f3_instr", instr, 16'h3334);
    fe(16);
    chk("f16_instr", instr, 16'hF000);
    chk("f16_valid", instr_valid, 1);
    chk("f16_err", addr_err, 1);
    fe(48);
    chk("f48_nowrap", instr, 16'hF000);
    chk("f48_err", addr_err, 1);
    fetch_req = 0;
    tick;
    chk("idle_err", addr_err, 0);
    chk("idle_valid", instr_valid, 0);
    fe(0);
    chk("pre_stall", instr, 16'h2213);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 6'(4 + i);
      tick;
      chk("stall_instr", instr, 16'h2213);
      chk("stall_valid", instr_valid, 1);
    end
    pc = 16;
    tick;
    chk("stall_oor_noerr", addr_err, 0);
    flush = 1;
    tick;
    chk("flush_instr", instr, 16'hF000);
    chk("flush_valid", instr_valid, 0);
    flush = 0; stall = 0; fetch_req = 0;
    ld(0, 16'h1234);
    chk("run_ld_noerr", addr_err, 0);
    chk("run_ld_cnt", ld_cnt, 3);
    fe(0);
    chk("run_ld_nowrite", instr, 16'h2213);
    fetch_req = 0; start = 1; halt = 1;
    tick;
    chk("start_halt_run", running, 1);
    start = 0; halt = 1; fetch_req = 1; pc = 0;
    tick;
    chk("halt_running", running, 0);
    chk("halt_valid", instr_valid, 0);
    chk("halt_instr", instr, 16'hF000);
    halt = 0; fetch_req = 0; start = 1; halt = 1;
    tick;
    chk("start_halt_load", running, 0);
    start = 0; halt = 0;
    for (int i = 0; i < 16; i++) ld(6'(i), 16'hA000 + 16'(i));
    chk("cnt_full", ld_cnt, 16);
    ld(5, 16'h5555);
    chk("cnt_sat", ld_cnt, 16);
    start = 1;
    tick;
    start = 0;
    fe(7);
    chk("f7_full", instr, 16'hA007);
    fe(5);
    chk("f5_rewritten", instr, 16'h5555);
    rst_n = 0;
    #1;
    chk("mid_rst_instr", instr, 16'hF000);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_cnt", ld_cnt, 0);
    fetch_req = 0;
    tick;
    rst_n = 1; start = 1;
    tick;
    start = 0;
    fe(7);
    chk("post_rst_f7", instr, 16'hF000);
    chk("post_rst_valid", instr_valid, 1);
    fetch_req = 0;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
